interrupt_request_unit: RTL and testbench
=========================================

Name: interrupt_request_unit

Overview:
- Sits directly upstream of the CPU interrupt handler.
- Conditions the raw interrupt sources: PPU vblank NMI, APU and mapper IRQ lines, and console soft reset. It also generates the power-on reset request.
- Arbitrates the sources by priority and offers a single request (kind plus vector address) to the handler with a valid/ack handshake at instruction boundaries.
- Replaces ad-hoc latching of raw PPU status and reset lines inside the handler.

Parameters:
- RESET_MIN_LOW, 4: consecutive cycles soft_reset_n must be low before a reset request is latched.
- POR_CYCLES, 8: cycles after rst release before the power-on reset request is offered.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- halt  in  1  freezes the request FSM; source capture continues
- ppu_vblank  in  1  PPU vblank flag (PPUSTATUS bit 7)
- ppu_nmi_en  in  1  PPUCTRL bit 7
- apu_irq_n  in  1  APU frame/DMC IRQ, level, active-low
- mapper_irq_n  in  1  cartridge IRQ, level, active-low
- soft_reset_n  in  1  console reset button, active-low
- i_flag  in  1  CPU status bit 2 (interrupt disable)
- insn_boundary  in  1  one-cycle pulse from the IE when an instruction retires
- req_ack  in  1  one-cycle pulse from the handler when it takes the offered request
- req_valid  out  1  a request is being offered
- req_kind  out  2  00 none, 01 IRQ, 10 NMI, 11 RESET
- req_vector  out  16  vector address: FFFE, FFFA or FFFC; 0000 when none
- nmi_pending  out  1  NMI latch state, for debug and status
- reset_pending  out  1  reset latch state

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to ST_POR and the POR counter is cleared.
  - req_valid=0, req_kind=00, req_vector=0000.
  - nmi_pending=0, reset_pending=0, debounce counter=0, nmi edge register=0.
- NMI source:
  - The source is nmi_src = ppu_vblank & ppu_nmi_en, registered once.
  - A rising edge of nmi_src sets nmi_pending.
  - Setting ppu_nmi_en while vblank is already high counts as an edge and raises NMI.
  - nmi_pending clears only on req_ack while req_kind=10.
  - If a new edge and the ack land in the same cycle, set wins and nmi_pending stays 1.
- IRQ source:
  - The source is irq_lvl = !apu_irq_n | !mapper_irq_n. It is level-sensitive and never latched.
  - An IRQ is eligible only when irq_lvl=1 and i_flag=0, sampled on the insn_boundary cycle.
- Soft reset:
  - The debounce counter increments while soft_reset_n=0, saturating at RESET_MIN_LOW, and clears when soft_reset_n=1.
  - reset_pending sets on the cycle the counter reaches RESET_MIN_LOW.
  - reset_pending clears on req_ack with req_kind=11.
  - Set wins over a simultaneous clear.
- Priority: RESET > NMI > IRQ. Arbitration happens only on insn_boundary in ST_IDLE.
- FSM:
  - ST_POR:
    - The POR counter counts to POR_CYCLES-1, then the unit sets reset_pending and moves to ST_IDLE.
    - An insn_boundary during ST_POR is ignored.
  - ST_IDLE:
    - On insn_boundary with any eligible source, latch the winner into req_kind/req_vector, assert req_valid the next cycle, and go to ST_OFFER.
    - With no eligible source, stay in ST_IDLE and keep the outputs at none.
  - ST_OFFER:
    - req_kind and req_vector are held stable, and are not re-arbitrated even if a higher-priority source arrives.
    - On req_ack: req_valid drops next cycle, the corresponding latch clears, and the FSM returns to ST_IDLE.
    - IRQ deassertion during ST_OFFER does not withdraw the request.
  - req_ack outside ST_OFFER is ignored.
- Halt:
  - While halt=1 the FSM and its outputs are frozen, and insn_boundary and req_ack are ignored.
  - The NMI edge detector, the debounce counter and the latch set logic keep running, so no events are lost.
- Latency: insn_boundary at cycle N gives req_valid=1 at cycle N+1.
- Throughput: at most one request per instruction boundary. Back-to-back requests need a new boundary after the ack.

Decomposition:
- Shared package cpu_int_pkg holds:
  - the req_kind encodings (INT_NONE, INT_IRQ, INT_NMI, INT_RESET);
  - the vector constants VEC_NMI=16'hFFFA, VEC_RESET=16'hFFFC, VEC_IRQ=16'hFFFE.
- One natural sub-module: int_edge_latch, a registered rising-edge detector with a set-priority latch and clear input. The NMI path instantiates it.

Test Plan:
- Power-on: release rst, pulse insn_boundary every 4 cycles -> req_valid first at the boundary after cycle 8 with kind 11, vector FFFC. Ack -> reset_pending=0 and req_valid=0 next cycle.
- NMI: ppu_nmi_en=1, raise vblank, boundary -> kind 10, vector FFFA. Hold vblank high after ack -> no second NMI. Drop and raise vblank -> a new NMI.
- IRQ masking: mapper_irq_n=0 with i_flag=1, boundary -> no request. Set i_flag=0, boundary -> kind 01, vector FFFE.
- Priority: NMI latched plus apu IRQ active plus reset held 4 cycles, then boundary -> kind 11. Ack, boundary -> kind 10. Ack, boundary -> kind 01.
- Debounce: soft_reset_n low for 3 cycles -> reset_pending stays 0. Low for 4 cycles -> 1.
- Halt/race: halt=1 during a vblank edge -> nmi_pending=1 but no offer. halt=0 then boundary -> offer. A vblank edge in the same cycle as the NMI ack -> nmi_pending remains 1.

Source files
------------

// File: rtl/cpu_int_pkg.sv
// Shared encodings for the CPU interrupt request path: request kinds,
// vector addresses and default timing parameters.
package cpu_int_pkg;

    typedef enum logic [1:0] {
        INT_NONE  = 2'b00,
        INT_IRQ   = 2'b01,
        INT_NMI   = 2'b10,
        INT_RESET = 2'b11
    } int_kind_e;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    localparam int RESET_MIN_LOW_DEF = 4;
    localparam int POR_CYCLES_DEF    = 8;

endpackage

// File: rtl/int_edge_latch.sv
// Registered rising-edge detector feeding a sticky latch; a new edge
// beats a simultaneous clear so an event arriving during an ack is kept.
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic clr,
    output logic pending
);

    logic src_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            src_q <= src;
            if (src && !src_q)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/interrupt_request_unit.sv
// Conditions NMI/IRQ/soft-reset sources, generates power-on reset and offers
// one prioritised request per instruction boundary over a valid/ack handshake.
module interrupt_request_unit
    import cpu_int_pkg::*;
#(
    parameter int RESET_MIN_LOW = RESET_MIN_LOW_DEF,
    parameter int POR_CYCLES    = POR_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        ppu_vblank,
    input  logic        ppu_nmi_en,
    input  logic        apu_irq_n,
    input  logic        mapper_irq_n,
    input  logic        soft_reset_n,
    input  logic        i_flag,
    input  logic        insn_boundary,
    input  logic        req_ack,
    output logic        req_valid,
    output logic [1:0]  req_kind,
    output logic [15:0] req_vector,
    output logic        nmi_pending,
    output logic        reset_pending
);

    localparam int DW = $clog2(RESET_MIN_LOW + 1);
    localparam int PW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;

    typedef enum logic [1:0] {ST_POR, ST_IDLE, ST_OFFER} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   por_q, por_d;
    logic [DW-1:0]   db_cnt;
    logic            valid_d;
    logic [1:0]      kind_d;
    logic [15:0]     vec_d;
    logic            por_set, nmi_clr, rst_clr, db_hit;

    wire nmi_src = ppu_vblank & ppu_nmi_en;
    wire irq_ok  = (!apu_irq_n || !mapper_irq_n) && !i_flag;

    int_edge_latch u_nmi (
        .clk     (clk),
        .rst     (rst),
        .src     (nmi_src),
        .clr     (nmi_clr),
        .pending (nmi_pending)
    );

    // Debounce runs regardless of halt so a button press is never dropped.
    assign db_hit = !soft_reset_n && (db_cnt == DW'(RESET_MIN_LOW - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            db_cnt        <= '0;
            reset_pending <= 1'b0;
        end else begin
            if (soft_reset_n)
                db_cnt <= '0;
            else if (db_cnt != DW'(RESET_MIN_LOW))
                db_cnt <= db_cnt + 1'b1;
            if (db_hit || por_set)
                reset_pending <= 1'b1;
            else if (rst_clr)
                reset_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_POR;
            por_q      <= '0;
            req_valid  <= 1'b0;
            req_kind   <= INT_NONE;
            req_vector <= 16'h0000;
        end else begin
            state_q    <= state_d;
            por_q      <= por_d;
            req_valid  <= valid_d;
            req_kind   <= kind_d;
            req_vector <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        por_d   = por_q;
        valid_d = req_valid;
        kind_d  = req_kind;
        vec_d   = req_vector;
        por_set = 1'b0;
        nmi_clr = 1'b0;
        rst_clr = 1'b0;
        if (!halt) begin
            case (state_q)
                ST_POR: begin
                    if (por_q == PW'(POR_CYCLES - 1)) begin
                        por_set = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        por_d = por_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (insn_boundary) begin
                        if (reset_pending) begin
                            kind_d = INT_RESET; vec_d = VEC_RESET;
                        end else if (nmi_pending) begin
                            kind_d = INT_NMI;   vec_d = VEC_NMI;
                        end else if (irq_ok) begin
                            kind_d = INT_IRQ;   vec_d = VEC_IRQ;
                        end
                        if (reset_pending || nmi_pending || irq_ok) begin
                            valid_d = 1'b1;
                            state_d = ST_OFFER;
                        end
                    end
                end
                ST_OFFER: begin
                    // Kind stays frozen until the handler takes it.
                    if (req_ack) begin
                        nmi_clr = (req_kind == INT_NMI);
                        rst_clr = (req_kind == INT_RESET);
                        valid_d = 1'b0;
                        kind_d  = INT_NONE;
                        vec_d   = 16'h0000;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_POR;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Directed self-checking bench for interrupt_request_unit.
module tb_interrupt_request_unit;

    logic        clk = 1'b0;
    logic        rst, halt, ppu_vblank, ppu_nmi_en, apu_irq_n, mapper_irq_n;
    logic        soft_reset_n, i_flag, insn_boundary, req_ack;
    logic        req_valid, nmi_pending, reset_pending;
    logic [1:0]  req_kind;
    logic [15:0] req_vector;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_request_unit dut (
        .clk           (clk),
        .rst           (rst),
        .halt          (halt),
        .ppu_vblank    (ppu_vblank),
        .ppu_nmi_en    (ppu_nmi_en),
        .apu_irq_n     (apu_irq_n),
        .mapper_irq_n  (mapper_irq_n),
        .soft_reset_n  (soft_reset_n),
        .i_flag        (i_flag),
        .insn_boundary (insn_boundary),
        .req_ack       (req_ack),
        .req_valid     (req_valid),
        .req_kind      (req_kind),
        .req_vector    (req_vector),
        .nmi_pending   (nmi_pending),
        .reset_pending (reset_pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic boundary();
        insn_boundary = 1'b1; tick(); insn_boundary = 1'b0;
    endtask

    task automatic ack();
        req_ack = 1'b1; tick(); req_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; halt = 1'b0; ppu_vblank = 1'b0; ppu_nmi_en = 1'b0;
        apu_irq_n = 1'b1; mapper_irq_n = 1'b1; soft_reset_n = 1'b0; i_flag = 1'b1;
        insn_boundary = 1'b1; req_ack = 1'b0;
        tick(6);
        insn_boundary = 1'b0; soft_reset_n = 1'b1;
        tick();
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", req_valid); end
        n_checks++; if (req_kind !== 2'b00) begin n_fail++; $display("FAIL reset_kind: got %b want 00", req_kind); end
        n_checks++; if (req_vector !== 16'h0000) begin n_fail++; $display("FAIL reset_vector: got %h want 0000", req_vector); end
        n_checks++; if (nmi_pending !== 1'b0) begin n_fail++; $display("FAIL reset_nmi_pending: got %b want 0", nmi_pending); end
        n_checks++; if (reset_pending !== 1'b0) begin n_fail++; $display("FAIL reset_reset_pending: got %b want 0", reset_pending); end
    endtask

    task automatic test_por();
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            insn_boundary = (i % 4 == 0);
            tick();
            insn_boundary = 1'b0;
            if (i == 7) begin
                n_checks++; if (reset_pending !== 1'b0) begin n_fail++; $display("FAIL por_early: got %b want 0", reset_pending); end
            end
        end
        n_checks++; if (reset_pending !== 1'b1) begin n_fail++; $display("FAIL por_pending: got %b want 1", reset_pending); end
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL por_boundary_ignored: got %b want 0", req_valid); end
        tick(3);
        boundary();
        n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL por_valid: got %b want 1", req_valid); end
        n_checks++; if (req_kind !== 2'b11) begin n_fail++; $display("FAIL por_kind: got %b want 11", req_kind); end
        n_checks++; if (req_vector !== 16'hFFFC) begin n_fail++; $display("FAIL por_vector: got %h want fffc", req_vector); end
        tick(2);
        n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL por_hold: got %b want 1", req_valid); end
        ack();
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL por_ack_valid: got %b want 0", req_valid); end
        n_checks++; if (reset_pending !== 1'b0) begin n_fail++; $display("FAIL por_ack_pending: got %b want 0", reset_pending); end
        n_checks++; if (req_vector !== 16'h0000) begin n_fail++; $display("FAIL por_ack_vector: got %h want 0000", req_vector); end
    endtask

    task automatic test_nmi();
        ppu_nmi_en = 1'b1; ppu_vblank = 1'b1;
        tick();
        n_checks++; if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL nmi_set: got %b want 1", nmi_pending); end
        boundary();
        n_checks++; if (req_kind !== 2'b10) begin n_fail++; $display("FAIL nmi_kind: got %b want 10", req_kind); end
        n_checks++; if (req_vector !== 16'hFFFA) begin n_fail++; $display("FAIL nmi_vector: got %h want fffa", req_vector); end
        ack();
        n_checks++; if (nmi_pending !== 1'b0) begin n_fail++; $display("FAIL nmi_clear: got %b want 0", nmi_pending); end
        tick(2);
        boundary();
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL nmi_level_no_retrigger: got %b want 0", req_valid); end
        ppu_vblank = 1'b0; tick();
        ppu_vblank = 1'b1; tick();
        n_checks++; if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL nmi_second_edge: got %b want 1", nmi_pending); end
        boundary();
        n_checks++; if (req_kind !== 2'b10) begin n_fail++; $display("FAIL nmi_second_kind: got %b want 10", req_kind); end
        ack();
        // Enabling NMI while vblank is already up must count as an edge.
        ppu_nmi_en = 1'b0; tick();
        ppu_nmi_en = 1'b1; tick();
        n_checks++; if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL nmi_enable_edge: got %b want 1", nmi_pending); end
        boundary(); ack();
        ppu_vblank = 1'b0; tick();
    endtask

    task automatic test_irq_mask();
        mapper_irq_n = 1'b0; i_flag = 1'b1;
        boundary();
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", req_valid); end
        i_flag = 1'b0;
        boundary();
        n_checks++; if (req_kind !== 2'b01) begin n_fail++; $display("FAIL irq_kind: got %b want 01", req_kind); end
        n_checks++; if (req_vector !== 16'hFFFE) begin n_fail++; $display("FAIL irq_vector: got %h want fffe", req_vector); end
        mapper_irq_n = 1'b1; tick();
        n_checks++; if (req_valid !== 1'b1 || req_kind !== 2'b01) begin n_fail++; $display("FAIL irq_not_withdrawn: got %b/%b want 1/01", req_valid, req_kind); end
        ack();
        boundary();
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL irq_gone: got %b want 0", req_valid); end
        i_flag = 1'b1;
    endtask

    task automatic test_priority();
        ppu_vblank = 1'b1; apu_irq_n = 1'b0; i_flag = 1'b0;
        soft_reset_n = 1'b0; tick(4); soft_reset_n = 1'b1;
        boundary();
        n_checks++; if (req_kind !== 2'b11) begin n_fail++; $display("FAIL prio_reset: got %b want 11", req_kind); end
        ack(); boundary();
        n_checks++; if (req_kind !== 2'b10) begin n_fail++; $display("FAIL prio_nmi: got %b want 10", req_kind); end
        ack(); boundary();
        n_checks++; if (req_kind !== 2'b01) begin n_fail++; $display("FAIL prio_irq: got %b want 01", req_kind); end
        ack();
        ppu_vblank = 1'b0; apu_irq_n = 1'b1; i_flag = 1'b1; tick();
    endtask

    task automatic test_debounce();
        soft_reset_n = 1'b0; tick(3); soft_reset_n = 1'b1; tick();
        n_checks++; if (reset_pending !== 1'b0) begin n_fail++; $display("FAIL debounce_short: got %b want 0", reset_pending); end
        soft_reset_n = 1'b0; tick(3);
        n_checks++; if (reset_pending !== 1'b0) begin n_fail++; $display("FAIL debounce_three: got %b want 0", reset_pending); end
        tick();
        n_checks++; if (reset_pending !== 1'b1) begin n_fail++; $display("FAIL debounce_four: got %b want 1", reset_pending); end
        soft_reset_n = 1'b1;
        boundary(); ack();
        n_checks++; if (reset_pending !== 1'b0) begin n_fail++; $display("FAIL debounce_ack: got %b want 0", reset_pending); end
    endtask

    task automatic test_halt_race();
        halt = 1'b1; ppu_vblank = 1'b1; tick();
        n_checks++; if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL halt_nmi_capture: got %b want 1", nmi_pending); end
        boundary();
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_no_offer: got %b want 0", req_valid); end
        halt = 1'b0;
        boundary();
        n_checks++; if (req_valid !== 1'b1 || req_kind !== 2'b10) begin n_fail++; $display("FAIL halt_release_offer: got %b/%b want 1/10", req_valid, req_kind); end
        halt = 1'b1; ack(); halt = 1'b0;
        n_checks++; if (req_valid !== 1'b1 || nmi_pending !== 1'b1) begin n_fail++; $display("FAIL halt_ack_ignored: got %b/%b want 1/1", req_valid, nmi_pending); end
        ppu_vblank = 1'b0; tick();
        ppu_vblank = 1'b1; ack();
        n_checks++; if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b want 1", nmi_pending); end
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL race_valid: got %b want 0", req_valid); end
        ack();
        n_checks++; if (nmi_pending !== 1'b1) begin n_fail++; $display("FAIL idle_ack_ignored: got %b want 1", nmi_pending); end
        boundary();
        n_checks++; if (req_kind !== 2'b10) begin n_fail++; $display("FAIL race_reoffer: got %b want 10", req_kind); end
        ack();
        n_checks++; if (nmi_pending !== 1'b0) begin n_fail++; $display("FAIL race_final_clear: got %b want 0", nmi_pending); end
        ppu_vblank = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_por();
        test_nmi();
        test_irq_mask();
        test_priority();
        test_debounce();
        test_halt_race();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
